// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor. A START accepted in IDLE or DONE latches
//   the operands, then one bit per clock is processed LSB first. After WIDTH
//   shift cycles the full result, borrow-out, overflow and zero flags are
//   published together and DONE pulses for one cycle.
//
// Ports
//   CLK   : clock, rising-edge active
//   RST   : synchronous, active-high reset
//   START : begin a subtraction (ignored while BUSY)
//   A, B  : unsigned minuend / subtrahend, sampled on START acceptance
//   BIN   : borrow-in, sampled on START acceptance
//   DIFF  : registered result (A - B - BIN) mod 2^WIDTH
//   BOUT  : registered borrow-out
//   OVF   : registered two's-complement overflow
//   ZERO  : registered flag, high when DIFF == 0
//   BUSY  : high while bits are being shifted
//   DONE  : one-cycle completion strobe
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT,
  output logic             OVF,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             borrow_reg;
  logic [CW-1:0]    cnt_reg;
  // Holds the WIDTH-1 already-computed bits; the final bit is merged in on
  // the completion edge, so the top bit never needs a storage slot.
  logic [WIDTH-2:0] res_reg;
  logic [WIDTH-2:0] res_next;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             borrow_next;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] diff_final;

  // One-bit full subtractor on the current LSBs of the operand shifters.
  assign a_bit       = a_reg[0];
  assign b_bit       = b_reg[0];
  assign d_bit       = a_bit ^ b_bit ^ borrow_reg;
  assign borrow_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_reg);

  assign accept   = START && (state_reg != S_SHIFT);
  assign last_bit = (state_reg == S_SHIFT) && (cnt_reg == CW'(WIDTH - 1));

  // Result shifter: new bit enters at the top, everything else moves down.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_res
      if (gi == WIDTH - 2) begin : g_top
        assign res_next[gi] = d_bit;
      end else begin : g_mid
        assign res_next[gi] = res_reg[gi+1];
      end
    end
  endgenerate

  assign diff_final = {d_bit, res_reg};

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (START) state_next = S_SHIFT;
      S_SHIFT: if (last_bit) state_next = S_DONE;
      S_DONE:  state_next = START ? S_SHIFT : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    case (state_reg)
      S_SHIFT: BUSY = 1'b1;
      S_DONE:  DONE = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, bit-serial processing and result publication.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_reg      <= '0;
      b_reg      <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
      res_reg    <= '0;
      DIFF       <= '0;
      BOUT       <= 1'b0;
      OVF        <= 1'b0;
      ZERO       <= 1'b1;
    end else if (accept) begin
      a_reg      <= A;
      b_reg      <= B;
      borrow_reg <= BIN;
      cnt_reg    <= '0;
      res_reg    <= '0;
    end else if (state_reg == S_SHIFT) begin
      a_reg      <= a_reg >> 1;
      b_reg      <= b_reg >> 1;
      borrow_reg <= borrow_next;
      cnt_reg    <= cnt_reg + 1'b1;
      res_reg    <= res_next;
      if (last_bit) begin
        // On the last bit a_bit/b_bit are the operand MSBs and d_bit is the
        // result MSB, so overflow falls out without keeping copies of A/B.
        DIFF <= diff_final;
        BOUT <= borrow_next;
        OVF  <= (a_bit ^ b_bit) & (d_bit ^ a_bit);
        ZERO <= (diff_final == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Randomised and directed stimulus for serial_subtractor (WIDTH=8). Stimulus
//   pushes the expected result and completion cycle into a queue; a monitor
//   pops and compares whenever DONE is seen, and checks that published
//   outputs hold steady between completions.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         BIN = 1'b0;
  logic [W-1:0] DIFF;
  logic         BOUT;
  logic         OVF;
  logic         ZERO;
  logic         BUSY;
  logic         DONE;

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .START(START),
    .A    (A),
    .B    (B),
    .BIN  (BIN),
    .DIFF (DIFF),
    .BOUT (BOUT),
    .OVF  (OVF),
    .ZERO (ZERO),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;
    int           done_cyc;
  } exp_t;

  exp_t         q[$];
  int           n_cmp = 0;
  int           n_fail = 0;
  logic [W-1:0] hold_diff = '0;
  logic         hold_bout = 1'b0;
  logic         hold_ovf = 1'b0;
  logic         hold_zero = 1'b1;
  bit           hold_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bin, input int dc);
    exp_t m;
    int   d;
    d          = int'(a) - int'(b) - int'(bin);
    m.diff     = d[W-1:0];
    m.bout     = (int'(a) < int'(b) + int'(bin));
    m.ovf      = (a[W-1] != b[W-1]) && (m.diff[W-1] != a[W-1]);
    m.zero     = (m.diff == '0);
    m.done_cyc = dc;
    return m;
  endfunction

  // Called at a negedge: START is sampled on the next rising edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    A     = a;
    B     = b;
    BIN   = bin;
    START = 1'b1;
    q.push_back(model(a, b, bin, cyc + 1 + W));
    $display("issue  A=0x%02h B=0x%02h BIN=%0d at cycle %0d", a, b, bin, cyc + 1);
  endtask

  // Issue one operation, scramble inputs while busy, optionally pulse START
  // at iteration pulse_at, and return on the negedge where DONE is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input int pulse_at);
    int busy_cnt;
    bit got;
    busy_cnt = 0;
    got      = 1'b0;
    issue(a, b, bin);
    for (int i = 1; i <= 3 * W; i++) begin
      @(negedge CLK);
      START = 1'b0;
      A     = W'($urandom);
      B     = W'($urandom);
      BIN   = 1'($urandom);
      if (i == pulse_at) START = 1'b1;
      if (BUSY) busy_cnt++;
      if (DONE) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("busy_cycles", 32'(busy_cnt), 32'(W));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_diff", 32'(DIFF), 32'd0);
    chk("rst_bout", 32'(BOUT), 32'd0);
    chk("rst_ovf",  32'(OVF),  32'd0);
    chk("rst_zero", 32'(ZERO), 32'd1);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
  endtask

  // Called at a negedge with RST already high; flushes pending expectations.
  task automatic apply_reset_edge();
    @(posedge CLK);
    #1;
    q.delete();
    hold_diff  = '0;
    hold_bout  = 1'b0;
    hold_ovf   = 1'b0;
    hold_zero  = 1'b1;
    hold_valid = 1'b1;
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (DONE) begin
        chk("done_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          $display("done   DIFF=0x%02h BOUT=%0d OVF=%0d ZERO=%0d at cycle %0d (exp 0x%02h %0d %0d %0d @%0d)",
                   DIFF, BOUT, OVF, ZERO, cyc, e.diff, e.bout, e.ovf, e.zero, e.done_cyc);
          chk("diff", 32'(DIFF), 32'(e.diff));
          chk("bout", 32'(BOUT), 32'(e.bout));
          chk("ovf",  32'(OVF),  32'(e.ovf));
          chk("zero", 32'(ZERO), 32'(e.zero));
          chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
          hold_diff  = e.diff;
          hold_bout  = e.bout;
          hold_ovf   = e.ovf;
          hold_zero  = e.zero;
          hold_valid = 1'b1;
        end
      end else if (hold_valid) begin
        chk("hold_diff", 32'(DIFF), 32'(hold_diff));
        chk("hold_bout", 32'(BOUT), 32'(hold_bout));
        chk("hold_ovf",  32'(OVF),  32'(hold_ovf));
        chk("hold_zero", 32'(ZERO), 32'(hold_zero));
      end
    end
  end

  // Directed vectors with hand-computed results.
  logic [W-1:0] ta [4] = '{8'h05, 8'h00, 8'h80, 8'h00};
  logic [W-1:0] tb [4] = '{8'h03, 8'h01, 8'h01, 8'hFF};
  logic         tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [W-1:0] td [4] = '{8'h02, 8'hFF, 8'h7F, 8'h00};
  logic         tbo[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic         tov[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic         tz [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  // Stimulus
  initial begin
    bit got;

    // Power-on reset
    RST = 1'b1;
    @(negedge CLK);
    apply_reset_edge();
    @(negedge CLK);
    RST = 1'b0;
    chk_reset_outputs();

    // Directed vectors
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], tc[i], 0);
      chk("dir_diff", 32'(DIFF), 32'(td[i]));
      chk("dir_bout", 32'(BOUT), 32'(tbo[i]));
      chk("dir_ovf",  32'(OVF),  32'(tov[i]));
      chk("dir_zero", 32'(ZERO), 32'(tz[i]));
    end

    // START pulsed while busy must be ignored
    @(negedge CLK);
    run_op(8'h5A, 8'h33, 1'b1, 3);

    // START held high through DONE: back-to-back, no IDLE cycle
    @(negedge CLK);
    issue(8'h10, 8'h20, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge CLK);
      A = W'($urandom);
      B = W'($urandom);
      if (DONE) begin
        got = 1'b1;
        break;
      end
    end
    chk("b2b_first_done", 32'(got), 32'd1);
    run_op(8'hC3, 8'h3C, 1'b1, 0);

    // Reset in the middle of SHIFT, with START asserted on the same edge
    @(negedge CLK);
    issue(8'h77, 8'h11, 1'b0);
    repeat (3) begin
      @(negedge CLK);
      START = 1'b0;
    end
    RST   = 1'b1;
    START = 1'b1;
    A     = 8'hEE;
    apply_reset_edge();
    @(negedge CLK);
    RST   = 1'b0;
    START = 1'b0;
    chk_reset_outputs();
    run_op(8'h9C, 8'h2D, 1'b1, 0);

    // Randomised operations with random gaps (gap 0 restarts from DONE)
    repeat (40) begin
      int gap;
      run_op(W'($urandom), W'($urandom), 1'($urandom), 0);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge CLK);
    end

    // Drain
    for (int i = 0; i < 4 * W && q.size() > 0; i++) @(negedge CLK);
    chk("queue_drained", 32'(q.size()), 32'd0);
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port START, input, 1 bit: request to begin a subtraction, sampled on the rising edge.
REQ-005 SHALL have port A, input, WIDTH bits: unsigned minuend, sampled only when START is accepted.
REQ-006 SHALL have port B, input, WIDTH bits: unsigned subtrahend, sampled only when START is accepted.
REQ-007 SHALL have port BIN, input, 1 bit: borrow-in, sampled only when START is accepted.
REQ-008 SHALL have port DIFF, output, WIDTH bits: registered result.
REQ-009 SHALL have port BOUT, output, 1 bit: registered borrow-out.
REQ-010 SHALL have port OVF, output, 1 bit: registered two's-complement overflow flag.
REQ-011 SHALL have port ZERO, output, 1 bit: registered flag, high when DIFF == 0.
REQ-012 SHALL have port BUSY, output, 1 bit: high while the operation is in progress.
REQ-013 SHALL have port DONE, output, 1 bit: one-cycle completion strobe.

Function
REQ-014 SHALL implement a state machine with states IDLE, SHIFT and DONE.
REQ-015 START SHALL be accepted only on an edge where the state is IDLE or DONE; START SHALL be ignored in SHIFT.
REQ-016 On acceptance, the block SHALL:
- latch A, B and BIN into internal shift and borrow registers;
- clear the bit counter;
- enter SHIFT.
REQ-017 In SHIFT, each edge SHALL process one bit, LSB first:
- d = a_i XOR b_i XOR borrow;
- borrow' = (~a_i & b_i) | (~(a_i XOR b_i) & borrow);
- d SHALL be shifted into the result register from the MSB side.
REQ-018 After exactly WIDTH SHIFT edges, the state SHALL move to DONE; DONE SHALL be high for exactly one cycle, WIDTH clocks after the accepting edge.
REQ-019 From DONE, the next state SHALL be IDLE, or SHIFT if START is high on that edge.
REQ-020 BUSY SHALL equal 1 exactly while the state is SHIFT.
REQ-021 DIFF, BOUT, OVF and ZERO SHALL update together, only on the edge entering DONE, and SHALL hold their values until the next completion or reset.
REQ-022 Arithmetic SHALL be as follows:
- DIFF = (A − B − BIN) mod 2^WIDTH;
- BOUT = 1 iff A < B + BIN, unsigned, with B + BIN evaluated at WIDTH+1 bits;
- OVF = (A[MSB] != B[MSB]) & (DIFF[MSB] != A[MSB]).
REQ-023 Changes on A, B or BIN while BUSY SHALL NOT affect the result in progress.
REQ-024 Intermediate partial results SHALL NOT appear on DIFF.

Reset
REQ-025 RST high on an edge SHALL force state IDLE and set DIFF=0, BOUT=0, OVF=0, ZERO=1, BUSY=0 and DONE=0, regardless of state.
REQ-026 RST asserted mid-SHIFT SHALL abort the operation with no DONE pulse, and a START in the cycle after RST deasserts SHALL be accepted normally.
REQ-027 RST SHALL take priority over START on the same edge.

Verification (WIDTH=8)
REQ-028 A=0x05, B=0x03, BIN=0, START one cycle -> DONE 8 clocks later with DIFF=0x02, BOUT=0, OVF=0, ZERO=0; BUSY high for 8 cycles.
REQ-029 A=0x00, B=0x01, BIN=0 -> DIFF=0xFF, BOUT=1, OVF=0, ZERO=0.
REQ-030 A=0x80, B=0x01, BIN=0 -> DIFF=0x7F, BOUT=0, OVF=1; then A=0x00, B=0xFF, BIN=1 -> DIFF=0x00, BOUT=1, ZERO=1, OVF=0.
REQ-031 Pulse START at cycle 3 of a busy operation with different operands -> ignored, and the first result completes unchanged; START held high through DONE -> back-to-back operation begins with no IDLE cycle.
REQ-032 Assert RST at cycle 4 of SHIFT -> no DONE, all outputs at reset values; a fresh START afterwards produces the correct result 8 clocks later.
